// File: rtl/mem_io_slave_ws.sv
// mem_io_slave_ws: 8088 bus slave with a local byte array, window decode
// on the multiplexed bus and a programmable number of READY wait states.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | not selected; watching ALE for a hit on this window
// ADDR   | address latched; waiting for RD_N / WR_N (or a new ALE)
// WAIT   | READY low; counting down the programmed wait states
// RDATA  | driving MEM[OFFSET] onto DATA until RD_N rises
// WDATA  | one-cycle write phase; MEM[OFFSET] captured on the exit edge
// HOLD   | write done; waiting for WR_N to rise, no further writes
module mem_io_slave_ws #(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH_BITS  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    IS_IO       = 0,
  parameter int                    WAIT_STATES = 2,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ALE,
  input  logic                  IOM,
  input  logic                  RD_N,
  input  logic                  WR_N,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  output logic                  READY,
  output logic                  SEL
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam int         MEM_WORDS = 1 << DEPTH_BITS;
  localparam logic       IO_SPACE  = (IS_IO != 0);
  localparam logic       HAS_WAIT  = (WAIT_STATES > 0);
  // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES cycles (exit taken on the cycle the count reads zero).
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_io_slave_ws: WAIT_STATES must be in 0..15");
  end

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_BITS-1:0] offset_q, offset_d;
  logic                  tgt_wr_q, tgt_wr_d;
  logic                  mem_we;
  logic                  hit;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Window decode: only bits above the storage index take part in the match.
  assign hit = ALE && (IOM == IO_SPACE) &&
               (ADDRESS[ADDR_WIDTH-1:DEPTH_BITS] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_BITS]);

  // Next-state logic for the bus-cycle FSM, wait counter and latched offset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    tgt_wr_d = tgt_wr_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          offset_d = ADDRESS[DEPTH_BITS-1:0];
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ALE) begin
          // A fresh address phase overrides the pending one.
          if (hit) begin
            offset_d = ADDRESS[DEPTH_BITS-1:0];
          end else begin
            state_d = S_IDLE;
          end
        end else if (!RD_N || !WR_N) begin
          // Read wins when both strobes are low: direction is write only
          // when RD_N is still high.
          tgt_wr_d = RD_N;
          cnt_d    = WAIT_LOAD;
          if (HAS_WAIT) begin
            state_d = S_WAIT;
          end else if (RD_N) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_RDATA;
          end
        end
      end
      S_WAIT: begin
        if (RD_N && WR_N) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = tgt_wr_q ? S_WDATA : S_RDATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RDATA: begin
        if (RD_N) begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        // A strobe already gone by the write phase means the master gave
        // up on the cycle: nothing is stored.
        if (WR_N) begin
          state_d = S_IDLE;
        end else begin
          mem_we  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (WR_N) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      offset_q <= '0;
      tgt_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      tgt_wr_q <= tgt_wr_d;
    end
  end

  // Storage write; contents survive reset but a write landing on a reset
  // edge is dropped.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem_q[offset_q] <= DATA;
    end
  end

  // Moore outputs decoded from state only.
  always_comb begin
    READY = (state_q != S_WAIT);
    SEL   = (state_q != S_IDLE);
  end

  assign DATA = (state_q == S_RDATA) ? mem_q[offset_q] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_io_slave_ws.sv
// Bench: three slaves share one 8088-style bus (memory @0 ws=2, I/O @0x400
// ws=0, memory @0x400 ws=3). Stimulus queues expected responses; a negedge
// monitor measures each strobe and compares against the queue.
module tb_mem_io_slave_ws;

  localparam int               NS = 3;
  localparam int               WS_A [NS] = '{2, 0, 3};
  localparam logic             IO_A [NS] = '{1'b0, 1'b1, 1'b0};
  localparam logic [19:0]      BASE_A [NS] = '{20'h00000, 20'h00400, 20'h00400};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ale = 1'b0;
  logic        iom = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [19:0] addr = '0;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_data = '0;
  logic        mon_en = 1'b0;
  tri1  [7:0]  data_bus;
  logic [2:0]  ready_v, sel_v;

  assign data_bus = tb_drv ? tb_data : 8'bz;

  mem_io_slave_ws #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .DEPTH_BITS(10),
    .BASE_ADDR(20'h00000), .IS_IO(0), .WAIT_STATES(2), .INIT_FILE(""))
  u_s0 (.CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD_N(rd_n), .WR_N(wr_n),
        .ADDRESS(addr), .DATA(data_bus), .READY(ready_v[0]), .SEL(sel_v[0]));

  mem_io_slave_ws #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .DEPTH_BITS(10),
    .BASE_ADDR(20'h00400), .IS_IO(1), .WAIT_STATES(0), .INIT_FILE(""))
  u_s1 (.CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD_N(rd_n), .WR_N(wr_n),
        .ADDRESS(addr), .DATA(data_bus), .READY(ready_v[1]), .SEL(sel_v[1]));

  mem_io_slave_ws #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .DEPTH_BITS(10),
    .BASE_ADDR(20'h00400), .IS_IO(0), .WAIT_STATES(3), .INIT_FILE(""))
  u_s2 (.CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD_N(rd_n), .WR_N(wr_n),
        .ADDRESS(addr), .DATA(data_bus), .READY(ready_v[2]), .SEL(sel_v[2]));

  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    int         waits;
    bit         chk_data;
    logic [7:0] data;
    logic [2:0] sel;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem_m [NS][1024];
  bit         known [NS][1024];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slave_of(input logic io, input logic [19:0] a);
    logic [19:0] b;
    for (int s = 0; s < NS; s++) begin
      b = BASE_A[s];
      if (io == IO_A[s] && a[19:10] == b[19:10]) return s;
    end
    return -1;
  endfunction

  // op: 0 = read, 1 = write, 2 = both strobes low. len = strobe low cycles.
  task automatic bus_cycle(input logic io, input logic [19:0] a, input int op,
                           input logic [7:0] wdat, input int len,
                           input bit dbl, input logic io0, input logic [19:0] a0);
    exp_t e;
    int   s, w;
    int   off;
    bit   done_rd;
    s   = slave_of(io, a);
    w   = (s >= 0) ? WS_A[s] : 0;
    off = int'(a[9:0]);
    e.is_wr = (op == 1);
    e.waits = (s >= 0) ? ((len < w) ? len : w) : 0;
    e.sel   = (s >= 0) ? (3'b001 << s) : 3'b000;
    done_rd = (s >= 0) && (len >= w + 1);
    e.chk_data = (op != 1) && (!done_rd || known[s][off]);
    e.data  = done_rd ? mem_m[s][off] : 8'hFF;
    sb_q.push_back(e);
    if (op == 1 && s >= 0 && len >= w + 2) begin
      mem_m[s][off] = wdat;
      known[s][off] = 1'b1;
    end
    if (dbl) begin
      @(posedge clk); #1;
      ale = 1'b1; iom = io0; addr = a0;
    end
    @(posedge clk); #1;
    ale = 1'b1; iom = io; addr = a;
    @(posedge clk); #1;
    ale = 1'b0; iom = 1'($urandom); addr = 20'($urandom);
    rd_n = (op == 1);
    wr_n = (op == 0);
    if (op == 1) begin
      tb_drv = 1'b1; tb_data = wdat;
    end
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (op == 1 && k == w + 2) tb_data = ~wdat;
    end
    rd_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: measures each strobe (wait count, first ready data, SEL seen).
  initial begin
    int         k, waits;
    bit         active, got, strobe, prev_strobe, prev_rd;
    logic [7:0] dat;
    logic [2:0] sel_acc;
    exp_t       e;
    active = 0; got = 0; prev_strobe = 0; prev_rd = 1; k = 0; waits = 0;
    dat = '0; sel_acc = '0;
    forever begin
      @(negedge clk);
      strobe = !rd_n || !wr_n;
      if (mon_en) begin
        if (!active && strobe && !prev_strobe) begin
          active = 1; got = 0; k = 1; waits = 0; sel_acc = '0;
        end else if (active) begin
          k++;
        end
        if (active) begin
          sel_acc |= sel_v;
          if (!(&ready_v)) waits++;
          if (k >= 2 && (&ready_v) && !got) begin
            got = 1; dat = data_bus;
          end
          if (got && !strobe) begin
            active = 0;
            if (sb_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL sb_pop: got empty queue expected an entry at %0t", $time);
            end else begin
              e = sb_q.pop_front();
              check("wait_states", 32'(waits), 32'(e.waits));
              check("sel_seen", 32'(sel_acc), 32'(e.sel));
              if (!e.is_wr && e.chk_data) check("read_data", 32'(dat), 32'(e.data));
            end
          end else if (k > 40) begin
            active = 0;
            n_checks++; n_fail++;
            $display("FAIL strobe_timeout: got %0d cycles expected release", k);
          end
        end
        if (!tb_drv && rd_n && prev_rd) check("bus_idle_z", 32'(data_bus), 32'hFF);
      end
      prev_strobe = strobe;
      prev_rd = rd_n;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] b;
    int          s, op, len;
    logic        io;
    logic [19:0] a;

    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 1024; j++) begin
        mem_m[i][j] = '0; known[i][j] = 1'b0;
      end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready_v), 32'h7);
    check("reset_sel", 32'(sel_v), 32'h0);
    check("reset_bus_z", 32'(data_bus), 32'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;

    // Directed cycles.
    bus_cycle(1'b0, 20'h00005, 1, 8'hA5, 5, 0, 1'b0, '0);
    bus_cycle(1'b1, 20'h00410, 1, 8'h77, 3, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00005, 0, 8'h00, 4, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h0003C, 1, 8'h5A, 5, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h0003C, 0, 8'h00, 4, 0, 1'b0, '0);
    bus_cycle(1'b1, 20'h00005, 1, 8'hEE, 4, 0, 1'b0, '0);
    bus_cycle(1'b1, 20'h00005, 0, 8'h00, 4, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00805, 1, 8'hEE, 4, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00005, 0, 8'h00, 4, 0, 1'b0, '0);
    bus_cycle(1'b1, 20'h00410, 0, 8'h00, 3, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00420, 1, 8'h99, 6, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00420, 1, 8'h11, 1, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00420, 0, 8'h00, 2, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00420, 0, 8'h00, 5, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h0003C, 2, 8'h00, 4, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h0003C, 0, 8'h00, 3, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h00005, 0, 8'h00, 4, 1, 1'b0, 20'h0003C);

    // Randomized cycles on a small offset pool so reads revisit writes.
    for (int n = 0; n < 150; n++) begin
      s   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 7));
      op  = int'($urandom_range(0, 9));
      op  = (op < 5) ? 0 : ((op < 9) ? 1 : 2);
      if (s < NS) begin
        b  = BASE_A[s];
        io = IO_A[s];
        a  = {b[19:10], 10'(($urandom_range(0, 7) * 37) & 10'h3FF)};
      end else begin
        io = 1'($urandom);
        a  = {10'($urandom_range(2, 1023)), 10'($urandom)};
      end
      bus_cycle(io, a, op, 8'($urandom), len, ($urandom_range(0, 4) == 0),
                1'($urandom), 20'($urandom));
    end

    // Reset in the middle of a read data phase.
    mon_en = 1'b0;
    @(posedge clk); #1;
    ale = 1'b1; iom = 1'b0; addr = 20'h00005;
    @(posedge clk); #1;
    ale = 1'b0; rd_n = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre_reset_data", 32'(data_bus), 32'(mem_m[0][5]));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midread_reset_ready", 32'(ready_v), 32'h7);
    check("midread_reset_sel", 32'(sel_v), 32'h0);
    check("midread_reset_bus_z", 32'(data_bus), 32'hFF);
    @(posedge clk); #1;
    rd_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    bus_cycle(1'b0, 20'h00005, 0, 8'h00, 4, 0, 1'b0, '0);
    bus_cycle(1'b0, 20'h0003C, 0, 8'h00, 4, 0, 1'b0, '0);

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
